// File: rtl/operand_pkg.sv
// Shared types and helpers for the operand pairing path feeding the add/subtract stage.
package operand_pkg;

  localparam int OP_NBITS = 8;
  localparam int OP_DEPTH = 4;

  typedef struct packed {
    logic [OP_NBITS-1:0] a;
    logic [OP_NBITS-1:0] b;
  } pair_t;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Show-ahead pair FIFO; the head is a register so downstream operands stay stable all cycle.
module pair_fifo
  import operand_pkg::*;
#(
  parameter type T     = pair_t,
  parameter int  DEPTH = OP_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  T                        din,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level,
  output T                        head
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, rd_nxt;
  logic [PW:0]   level_q, level_d;
  T              head_q, head_d;
  T              mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (level_q == (PW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !clr && !full;
  assign do_pop  = pop && !clr && !empty;
  assign rd_nxt  = rd_q + PW'(1);

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    head_d  = head_q;
    if (clr) begin
      rd_d    = '0;
      wr_d    = '0;
      level_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_nxt;
      if (do_push && !do_pop)      level_d = level_q + (PW+1)'(1);
      else if (do_pop && !do_push) level_d = level_q - (PW+1)'(1);
      // New head comes from storage if a second entry exists, otherwise straight from the push.
      if (do_pop && (level_q > (PW+1)'(1)))              head_d = mem_q[rd_nxt];
      else if (do_push && ((level_q == '0) || do_pop))   head_d = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign level = level_q;
  assign head  = head_q;

endmodule

// File: rtl/operand_pairer.sv
// Groups a serial operand stream into (A, B) pairs and presents the head pair to the add/sub stage.
//   phase | meaning
//   PH_A  | next accepted word is operand A (latched into half_a)
//   PH_B  | next accepted word is operand B (pushed with half_a as a pair)
module operand_pairer
  import operand_pkg::*;
#(
  parameter int NBITS = OP_NBITS,
  parameter int DEPTH = OP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [NBITS-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NBITS-1:0]      a,
  output logic [NBITS-1:0]      b,
  output logic                  pair_valid,
  input  logic                  pair_ready,
  output logic [clog2(DEPTH):0] level
);

  typedef struct packed {
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
  } op_pair_t;

  phase_e           phase_q, phase_d;
  logic [NBITS-1:0] half_a_q, half_a_d;
  logic             accept, push, pop, full, empty;
  op_pair_t         head, push_pair;

  // in_ready looks only at registered state so no ready-to-ready path forms through pair_ready.
  assign in_ready  = (phase_q == PH_A) || !full;
  assign accept    = in_valid && in_ready;
  assign push      = accept && (phase_q == PH_B);
  assign pop       = !empty && pair_ready;
  assign push_pair = '{a: half_a_q, b: in_data};

  always_comb begin
    phase_d  = phase_q;
    half_a_d = half_a_q;
    if (clr) begin
      phase_d = PH_A;
    end else if (accept) begin
      if (phase_q == PH_A) begin
        half_a_d = in_data;
        phase_d  = PH_B;
      end else begin
        phase_d  = PH_A;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_A;
      half_a_q <= '0;
    end else begin
      phase_q  <= phase_d;
      half_a_q <= half_a_d;
    end
  end

  pair_fifo #(
    .T     (op_pair_t),
    .DEPTH (DEPTH)
  ) u_pair_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (push_pair),
    .full  (full),
    .empty (empty),
    .level (level),
    .head  (head)
  );

  assign a          = head.a;
  assign b          = head.b;
  assign pair_valid = !empty;

endmodule
